// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core: opcodes, datapath widths and the
// LM/SM sequencer state type.
package risc_pkg;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int REG_LIST_W = 8;
  localparam int ADDR_W     = 16;
  localparam int OFFSET_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lmsm_state_t;

endpackage

// File: rtl/lsb_prio_enc8.sv
// Lowest-set-bit encoder over an 8-bit register mask: index of the bit,
// the bit as a one-hot clear mask, and flags for "any set" / "exactly one set".
module lsb_prio_enc8
  import risc_pkg::*;
(
  input  logic [REG_LIST_W-1:0] mask,
  output logic [2:0]            idx,
  output logic                  any,
  output logic [REG_LIST_W-1:0] one_hot_clear,
  output logic                  single
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx           = 3'd0;
    one_hot_clear = '0;
    for (int i = REG_LIST_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx           = 3'(i);
        one_hot_clear = REG_LIST_W'(1) << i;
      end
    end
  end

  assign any    = |mask;
  assign single = any && ((mask & (mask - REG_LIST_W'(1))) == '0);

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands a decoded LM/SM into one single-register memory micro-op per set
// bit of the register list, lowest register first, one per accepted cycle.
module lmsm_sequencer
  import risc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_lm,
  input  logic [REG_LIST_W-1:0] reg_list,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  hold_fetch,
  output logic                  uop_valid,
  output logic                  uop_is_load,
  output logic [2:0]            uop_reg,
  output logic [ADDR_W-1:0]     uop_addr,
  output logic                  uop_last
);

  lmsm_state_t           state_q, state_d;
  logic [REG_LIST_W-1:0] mask_q, mask_d;
  logic                  is_lm_q, is_lm_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;

  logic [2:0]            enc_idx;
  logic                  enc_any;
  logic [REG_LIST_W-1:0] enc_bit;
  logic                  enc_single;
  logic                  accept;
  logic                  start_ok;

  lsb_prio_enc8 u_enc (
    .mask          (mask_q),
    .idx           (enc_idx),
    .any           (enc_any),
    .one_hot_clear (enc_bit),
    .single        (enc_single)
  );

  assign busy        = (state_q == RUN);
  assign uop_valid   = busy && !flush;
  assign uop_is_load = is_lm_q;
  assign uop_reg     = enc_idx;
  assign uop_addr    = base_q + ADDR_W'(offset_q);
  assign uop_last    = busy && enc_single;

  assign start_ok    = start && (reg_list != '0) && !flush;
  assign hold_fetch  = busy || start_ok;
  assign accept      = uop_valid && !stall_in && enc_any;

  // Flush outranks acceptance; a start seen during RUN is simply dropped.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    is_lm_d  = is_lm_q;
    base_d   = base_q;
    offset_d = offset_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = RUN;
          mask_d   = reg_list;
          is_lm_d  = is_lm;
          base_d   = base_addr;
          offset_d = '0;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          mask_d  = '0;
        end else if (accept) begin
          mask_d   = mask_q & ~enc_bit;
          offset_d = offset_q + OFFSET_W'(1);
          if (enc_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      is_lm_q  <= 1'b0;
      base_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      is_lm_q  <= is_lm_d;
      base_q   <= base_d;
      offset_q <= offset_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge against hand-computed values.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_lm;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        stall_in;
  logic        flush;
  logic        busy;
  logic        hold_fetch;
  logic        uop_valid;
  logic        uop_is_load;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
  logic        uop_last;

  int n_vec = 0;
  int n_err = 0;

  lmsm_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_lm       (is_lm),
    .reg_list    (reg_list),
    .base_addr   (base_addr),
    .stall_in    (stall_in),
    .flush       (flush),
    .busy        (busy),
    .hold_fetch  (hold_fetch),
    .uop_valid   (uop_valid),
    .uop_is_load (uop_is_load),
    .uop_reg     (uop_reg),
    .uop_addr    (uop_addr),
    .uop_last    (uop_last)
  );

  always #5 clk = ~clk;

  // {uop_valid, uop_is_load, uop_reg, uop_addr, uop_last}
  function automatic logic [21:0] uop_pack();
    return {uop_valid, uop_is_load, uop_reg, uop_addr, uop_last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    is_lm     = 1'b0;
    reg_list  = 8'h00;
    base_addr = 16'h0000;
    stall_in  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] obs;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    obs = {busy, hold_fetch, uop_pack()};
    n_vec++;
    if (obs !== 25'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 25'h0);
    end
    tick();
    start    = 1'b1;
    reg_list = 8'h03;
    @(negedge clk);
    n_vec++;
    if ({hold_fetch, busy} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL reset_hold_with_start: got %b expected %b", {hold_fetch, busy}, 2'b10);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if ({busy, uop_valid} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL reset_ignores_start: got %b expected %b", {busy, uop_valid}, 2'b00);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lm_basic();
    logic [2:0]  exp_reg [3] = '{3'd0, 3'd2, 3'd7};
    logic [15:0] exp_addr[3] = '{16'h0100, 16'h0101, 16'h0102};
    logic [21:0] exp;
    start = 1'b1; is_lm = 1'b1; reg_list = 8'h85; base_addr = 16'h0100;
    @(negedge clk);
    n_vec++;
    if ({hold_fetch, busy, uop_valid} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL lm_start_cycle: got %b expected %b", {hold_fetch, busy, uop_valid}, 3'b100);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = {1'b1, 1'b1, exp_reg[i], exp_addr[i], (i == 2)};
      n_vec++;
      if ({uop_pack(), busy, hold_fetch} !== {exp, 2'b11}) begin
        n_err++;
        $display("[TB] FAIL lm_uop%0d: got %h expected %h", i, {uop_pack(), busy, hold_fetch}, {exp, 2'b11});
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if ({busy, hold_fetch, uop_valid} !== 3'b000) begin
      n_err++;
      $display("[TB] FAIL lm_done: got %b expected %b", {busy, hold_fetch, uop_valid}, 3'b000);
    end
    tick();
  endtask

  task automatic test_sm_wrap();
    logic [21:0] exp;
    logic [15:0] addr;
    int          hold_cycles = 0;
    start = 1'b1; is_lm = 1'b0; reg_list = 8'hFF; base_addr = 16'hFFFE;
    @(negedge clk);
    if (hold_fetch) hold_cycles++;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (hold_fetch) hold_cycles++;
      addr = 16'hFFFE + 16'(i);
      exp  = {1'b1, 1'b0, 3'(i), addr, (i == 7)};
      n_vec++;
      if (uop_pack() !== exp) begin
        n_err++;
        $display("[TB] FAIL sm_uop%0d: got %h expected %h", i, uop_pack(), exp);
      end
      tick();
    end
    @(negedge clk);
    if (hold_fetch) hold_cycles++;
    n_vec++;
    if (hold_cycles !== 9) begin
      n_err++;
      $display("[TB] FAIL sm_hold_cycles: got %0d expected %0d", hold_cycles, 9);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL sm_done_busy: got %b expected %b", busy, 1'b0);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [21:0] exp_r1, exp_r3;
    exp_r1 = {1'b1, 1'b1, 3'd1, 16'h2000, 1'b0};
    exp_r3 = {1'b1, 1'b1, 3'd3, 16'h2001, 1'b1};
    start = 1'b1; is_lm = 1'b1; reg_list = 8'h0A; base_addr = 16'h2000;
    tick();
    idle_inputs();
    stall_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if (uop_pack() !== exp_r1) begin
      n_err++;
      $display("[TB] FAIL stall_n1: got %h expected %h", uop_pack(), exp_r1);
    end
    tick();
    stall_in = 1'b0;
    @(negedge clk);
    n_vec++;
    if (uop_pack() !== exp_r1) begin
      n_err++;
      $display("[TB] FAIL stall_n2_held: got %h expected %h", uop_pack(), exp_r1);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (uop_pack() !== exp_r3) begin
      n_err++;
      $display("[TB] FAIL stall_n3: got %h expected %h", uop_pack(), exp_r3);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL stall_done_busy: got %b expected %b", busy, 1'b0);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [21:0] exp_r0;
    exp_r0 = {1'b1, 1'b0, 3'd0, 16'h0300, 1'b0};
    start = 1'b1; is_lm = 1'b0; reg_list = 8'h0F; base_addr = 16'h0300;
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if (uop_pack() !== exp_r0) begin
      n_err++;
      $display("[TB] FAIL flush_r0: got %h expected %h", uop_pack(), exp_r0);
    end
    tick();
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({uop_valid, busy, hold_fetch} !== 3'b011) begin
      n_err++;
      $display("[TB] FAIL flush_cycle: got %b expected %b", {uop_valid, busy, hold_fetch}, 3'b011);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, hold_fetch, uop_valid, uop_last} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL flush_idle: got %b expected %b", {busy, hold_fetch, uop_valid, uop_last}, 4'b0000);
    end
    tick();
  endtask

  task automatic test_zero_list();
    start = 1'b1; is_lm = 1'b1; reg_list = 8'h00; base_addr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({hold_fetch, busy, uop_valid} !== 3'b000) begin
        n_err++;
        $display("[TB] FAIL zero_list_c%0d: got %b expected %b", i, {hold_fetch, busy, uop_valid}, 3'b000);
      end
      tick();
    end
    reg_list = 8'h01;
    flush    = 1'b1;
    @(negedge clk);
    n_vec++;
    if (hold_fetch !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL start_with_flush_hold: got %b expected %b", hold_fetch, 1'b0);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if ({busy, uop_valid} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL start_with_flush_idle: got %b expected %b", {busy, uop_valid}, 2'b00);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [21:0] exp;
    start = 1'b1; is_lm = 1'b1; reg_list = 8'hF0; base_addr = 16'h4000;
    tick();
    idle_inputs();
    @(negedge clk);
    exp = {1'b1, 1'b1, 3'd4, 16'h4000, 1'b0};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL rstrun_r4: got %h expected %h", uop_pack(), exp);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    exp = {1'b1, 1'b1, 3'd5, 16'h4001, 1'b0};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL rstrun_r5: got %h expected %h", uop_pack(), exp);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, hold_fetch, uop_pack()} !== 24'h0) begin
      n_err++;
      $display("[TB] FAIL rstrun_cleared: got %h expected %h", {busy, hold_fetch, uop_pack()}, 24'h0);
    end
    tick();
    start = 1'b1; is_lm = 1'b0; reg_list = 8'h01; base_addr = 16'h0010;
    tick();
    idle_inputs();
    @(negedge clk);
    exp = {1'b1, 1'b0, 3'd0, 16'h0010, 1'b1};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL rstrun_restart: got %h expected %h", uop_pack(), exp);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rstrun_restart_done: got %b expected %b", busy, 1'b0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    start = 1'b1; is_lm = 1'b1; reg_list = 8'h03; base_addr = 16'h0050;
    tick();
    // Start stays asserted with a different instruction; it must be ignored
    // while RUN and taken once the sequencer is back in IDLE.
    is_lm = 1'b0; reg_list = 8'h40; base_addr = 16'h0900;
    @(negedge clk);
    exp = {1'b1, 1'b1, 3'd0, 16'h0050, 1'b0};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL b2b_r0: got %h expected %h", uop_pack(), exp);
    end
    tick();
    @(negedge clk);
    exp = {1'b1, 1'b1, 3'd1, 16'h0051, 1'b1};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL b2b_r1: got %h expected %h", uop_pack(), exp);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({busy, hold_fetch, uop_valid} !== 3'b010) begin
      n_err++;
      $display("[TB] FAIL b2b_gap: got %b expected %b", {busy, hold_fetch, uop_valid}, 3'b010);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    exp = {1'b1, 1'b0, 3'd6, 16'h0900, 1'b1};
    n_vec++;
    if (uop_pack() !== exp) begin
      n_err++;
      $display("[TB] FAIL b2b_r6: got %h expected %h", uop_pack(), exp);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL b2b_done: got %b expected %b", busy, 1'b0);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_stall();
    test_flush();
    test_zero_list();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
